sha256: RTL and testbench
=========================

# sha256

Iterative SHA-256 compression engine for the Bitcoin hashing datapath. It accepts pre-padded 512-bit message blocks and chains 1 or 2 blocks into a single 256-bit digest, according to the message type. It performs one round per clock, produces a one-cycle completion strobe per block, and self-sequences continuously after reset with no start input. Double hashing (SHA-256d) is done by an upstream controller re-feeding the digest as a padded single-block HASH message.

## Interface
- No parameters.
- CLK  input  1  — system clock, rising-edge.
- nreset  input  1  — asynchronous reset, active-high, despite the port name.
- msg  input  512  — current padded block, big-endian words. W0 = msg[511:480] … W15 = msg[31:0]. Sampled in LOAD only.
- blk_type  input  2  — message type, sampled at LOAD of a message's first block. 0 = HASH (1 block), 1 = MERKLE_LEAF (2 blocks), 2 = HEADER (2 blocks), 3 = treated as 1 block.
- hash  output  256  — chaining value after the most recent block, H0 in [255:224] … H7 in [31:0].
- blk_done  output  1  — one-cycle pulse when a block's compression completes and hash updates.

## Operation
- State registers:
  - H0..H7 (chaining value)
  - a..h (working variables)
  - 16×32 W window
  - 6-bit round counter
  - block index (0/1)
  - latched block count
- FSM states: LOAD → ROUND (64 cycles) → UPDATE → LOAD…
- LOAD:
  - W ← msg.
  - a..h ← H. H is the standard IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) when block index = 0.
  - If block index = 0, latch block count from blk_type.
- ROUND t (t = 0..63):
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Shift: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - All sums mod 2^32.
  - Wt comes from the window for t < 16; otherwise Wt = σ1(Wt−2) + Wt−7 + σ0(Wt−15) + Wt−16, with the window shifting one word per round.
  - K is the standard 64-entry constant ROM.
- UPDATE:
  - Hi ← Hi + working variable (mod 2^32).
  - hash ← the updated H.
  - blk_done = 1.
  - If block index + 1 = block count: block index ← 0, and the next LOAD restarts from the IV. Otherwise block index increments and the next LOAD chains from H.
- msg and blk_type changes outside LOAD have no effect.
- Reset (async, any state, including mid-round):
  - state ← LOAD
  - block index ← 0
  - counters ← 0
  - H ← IV
  - hash ← 0
  - blk_done ← 0
  - After reset, any partially processed block is discarded.

## Timing
- Period is 66 cycles per block: 1 LOAD + 64 ROUND + 1 UPDATE.
- The first LOAD occurs at the first rising edge after nreset deasserts. That edge samples msg and blk_type.
- blk_done is registered: it is high for exactly the cycle following the UPDATE edge, i.e. it rises 66 edges after the first LOAD edge.
- hash changes only on the edge where blk_done rises, and holds between pulses.
- msg for the next block must be stable by the edge after blk_done rises; that edge is the next LOAD.
- Multi-block digest:
  - The final digest is valid at the second blk_done of a 2-block message.
  - The first pulse exposes the intermediate chaining value.
- Reset outputs: hash = 0, blk_done = 0.

## Test plan
- **Empty string (HASH):** blk_type=0, msg = 0x80000000 followed by zeros → first blk_done after 66 cycles, hash = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **"abc" (HASH):** msg = 61626380, 13 zero words, 00000018 → hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; the next message restarts from the IV.
- **Two-block NIST "abcdbcdecdef…nopq" (MERKLE_LEAF):**
  - Feed block 1, then change msg to block 2 on blk_done.
  - Pulse 1: hash = 85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a.
  - Pulse 2: hash = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- **HEADER type:** same two NIST blocks with blk_type=2 → identical digests. Then one "abc" block with blk_type=0 → ba7816bf… (IV restored).
- **Mid-block reset:** assert nreset at round 30 → hash = 0 and blk_done = 0 immediately. After release, "abc" gives the correct digest 66 cycles later.
- **blk_type/msg stability:** toggle blk_type and msg during ROUND cycles → digests unchanged; blk_done remains a single-cycle pulse every 66 cycles.

Source files
------------

// File: rtl/sha256.sv
// ----------------------------------------------------------------------------
// sha256 - iterative SHA-256 compression engine, one round per clock.
//
// The engine free-runs after reset: LOAD (1 cycle) -> ROUND (64 cycles) ->
// UPDATE (1 cycle) -> LOAD ... so every block takes 66 cycles. Messages of one
// or two pre-padded blocks are chained into one digest. blk_type sets the
// length and is sampled only at the first block's LOAD.
//
// Ports
//   CLK       in   1    rising-edge clock
//   nreset    in   1    asynchronous reset, active HIGH (despite the name)
//   msg       in   512  padded block, W0 = msg[511:480] .. W15 = msg[31:0]
//   blk_type  in   2    0 HASH (1 blk), 1 MERKLE_LEAF (2), 2 HEADER (2), 3 -> 1
//   hash      out  256  chaining value after last block, H0 in [255:224]
//   blk_done  out  1    one-cycle pulse, high the cycle after each UPDATE edge
// ----------------------------------------------------------------------------
module sha256 (
    input  logic         CLK,
    input  logic         nreset,
    input  logic [511:0] msg,
    input  logic [1:0]   blk_type,
    output logic [255:0] hash,
    output logic         blk_done
);

    typedef enum logic [1:0] {StLoad, StRound, StUpdate} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic [31:0]    r_hv [8];     // H0..H7 chaining value
    logic [31:0]    r_wv [8];     // a..h working variables
    logic [31:0]    r_w  [16];    // schedule window, r_w[0] is always W[t]
    logic [5:0]     r_round;
    logic           r_blk_idx;
    logic [1:0]     r_blk_cnt;
    logic [255:0]   r_hash;
    logic           r_done;

    logic [31:0]    w_t1;
    logic [31:0]    w_t2;
    logic [31:0]    w_wnext;
    logic [31:0]    w_base [8];
    logic [31:0]    w_hsum [8];
    logic [255:0]   w_hnew;
    logic [1:0]     w_type_cnt;

    assign hash     = r_hash;
    assign blk_done = r_done;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or posedge nreset) begin
        if (nreset) r_state <= StLoad;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:   w_state_next = StRound;
            StRound:  if (r_round == 6'd63) w_state_next = StUpdate;
            StUpdate: w_state_next = StLoad;
            default:  w_state_next = StLoad;
        endcase
    end

    // ------------------------------------------------------- combinational
    always_comb begin
        w_t1 = r_wv[7] + big_sig1(r_wv[4]) + ((r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6]))
             + K[r_round] + r_w[0];
        w_t2 = big_sig0(r_wv[0])
             + ((r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]));
        // Word that enters the window tail: W[t+16] from the current W[t..t+15]
        w_wnext = small_sig1(r_w[14]) + r_w[9] + small_sig0(r_w[1]) + r_w[0];
        w_type_cnt = (blk_type == 2'd1 || blk_type == 2'd2) ? 2'd2 : 2'd1;
        w_hnew = '0;
        for (int i = 0; i < 8; i++) begin
            w_base[i] = r_blk_idx ? r_hv[i] : IV[i];
            w_hsum[i] = r_hv[i] + r_wv[i];
            w_hnew[255-32*i -: 32] = w_hsum[i];
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge CLK or posedge nreset) begin
        if (nreset) begin
            for (int i = 0; i < 8; i++) begin
                r_hv[i] <= IV[i];
                r_wv[i] <= '0;
            end
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            r_round   <= '0;
            r_blk_idx <= 1'b0;
            r_blk_cnt <= '0;
            r_hash    <= '0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    for (int i = 0; i < 16; i++) r_w[i] <= msg[511-32*i -: 32];
                    for (int i = 0; i < 8; i++) begin
                        r_wv[i] <= w_base[i];
                        // First block: the chaining base restarts from the IV
                        if (!r_blk_idx) r_hv[i] <= IV[i];
                    end
                    if (!r_blk_idx) r_blk_cnt <= w_type_cnt;
                    r_round <= '0;
                end
                StRound: begin
                    for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                    r_w[15] <= w_wnext;
                    r_wv[0] <= w_t1 + w_t2;
                    r_wv[1] <= r_wv[0];
                    r_wv[2] <= r_wv[1];
                    r_wv[3] <= r_wv[2];
                    r_wv[4] <= r_wv[3] + w_t1;
                    r_wv[5] <= r_wv[4];
                    r_wv[6] <= r_wv[5];
                    r_wv[7] <= r_wv[6];
                    r_round <= r_round + 6'd1;
                end
                StUpdate: begin
                    for (int i = 0; i < 8; i++) r_hv[i] <= w_hsum[i];
                    r_hash <= w_hnew;
                    if (r_blk_cnt == ({1'b0, r_blk_idx} + 2'd1)) r_blk_idx <= 1'b0;
                    else                                         r_blk_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge nreset) begin
        if (nreset) r_done <= 1'b0;
        else        r_done <= (r_state == StUpdate);
    end

endmodule

// File: tb/tb_sha256.sv
module tb_sha256;

    logic         CLK = 1'b0;
    logic         nreset = 1'b1;
    logic [511:0] msg = '0;
    logic [1:0]   blk_type = '0;
    logic [255:0] hash;
    logic         blk_done;

    int vectors = 0;
    int miscompares = 0;

    sha256 dut (
        .CLK      (CLK),
        .nreset   (nreset),
        .msg      (msg),
        .blk_type (blk_type),
        .hash     (hash),
        .blk_done (blk_done)
    );

    always #5 CLK = ~CLK;

    localparam logic [255:0] IV_PACKED =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] MSG_NIST1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] MSG_NIST2 = {448'h0, 32'h00000000, 32'h000001c0};

    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_NIST_MID =
        256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
    localparam logic [255:0] D_NIST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    // Reference model state: message-level chaining, independent of the RTL FSM
    int           m_idx = 0;
    int           m_cnt = 1;
    logic [255:0] m_chain = '0;
    logic [255:0] prev_hash = '0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_msg();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[511-32*i -: 32] = $urandom();
        return m;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one block, returning the expected hash
    task automatic model_block(input logic [511:0] m, input logic [1:0] t,
                               output logic [255:0] exp);
        if (m_idx == 0) begin
            m_cnt = (t == 2'd1 || t == 2'd2) ? 2 : 1;
            m_chain = IV_PACKED;
        end
        m_chain = compress(m_chain, m);
        m_idx = (m_idx + 1 == m_cnt) ? 0 : m_idx + 1;
        exp = m_chain;
    endtask

    // Called at a negedge just before a LOAD edge. Returns at the negedge where
    // blk_done is first seen high (or when the cycle budget expires).
    task automatic run_block(input string tag, input logic [511:0] m, input logic [1:0] t,
                             input bit toggle);
        int edges;
        logic [255:0] exp;
        model_block(m, t, exp);
        msg = m;
        blk_type = t;
        @(posedge CLK);
        edges = 1;
        @(negedge CLK);
        check({tag, " pulse_low"}, {255'h0, blk_done}, 256'h0);
        check({tag, " hash_hold"}, hash, prev_hash);
        if (toggle) begin
            msg = rand_msg();
            blk_type = 2'($urandom_range(3));
        end
        while (blk_done !== 1'b1 && edges < 200) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
            if (toggle && blk_done !== 1'b1) begin
                msg = rand_msg();
                blk_type = 2'($urandom_range(3));
            end
        end
        check({tag, " latency"}, 256'(edges), 256'd66);
        check({tag, " digest"}, hash, exp);
        prev_hash = exp;
    endtask

    initial begin
        logic [511:0] rm;
        logic [1:0]   rt;

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset hash", hash, 256'h0);
        check("reset done", {255'h0, blk_done}, 256'h0);
        nreset = 1'b0;

        run_block("empty", MSG_EMPTY, 2'd0, 1'b0);
        check("empty known", hash, D_EMPTY);
        run_block("abc", MSG_ABC, 2'd0, 1'b0);
        check("abc known", hash, D_ABC);
        run_block("abc again", MSG_ABC, 2'd0, 1'b0);
        check("abc again known", hash, D_ABC);

        run_block("leaf b1", MSG_NIST1, 2'd1, 1'b0);
        check("leaf mid known", hash, D_NIST_MID);
        run_block("leaf b2", MSG_NIST2, 2'd0, 1'b0);
        check("leaf known", hash, D_NIST);

        run_block("hdr b1", MSG_NIST1, 2'd2, 1'b0);
        check("hdr mid known", hash, D_NIST_MID);
        run_block("hdr b2", MSG_NIST2, 2'd3, 1'b0);
        check("hdr known", hash, D_NIST);
        run_block("abc after hdr", MSG_ABC, 2'd0, 1'b0);
        check("abc after hdr known", hash, D_ABC);

        run_block("type3", rand_msg(), 2'd3, 1'b0);

        // Mid-block reset around round 30
        msg = MSG_ABC;
        blk_type = 2'd1;
        @(posedge CLK);
        repeat (31) @(posedge CLK);
        #2 nreset = 1'b1;
        #1;
        check("midrst hash", hash, 256'h0);
        check("midrst done", {255'h0, blk_done}, 256'h0);
        m_idx = 0;
        prev_hash = '0;
        repeat (2) @(negedge CLK);
        nreset = 1'b0;
        run_block("abc post rst", MSG_ABC, 2'd0, 1'b0);
        check("abc post rst known", hash, D_ABC);

        // Inputs scrambled during ROUND must not matter
        run_block("tog abc", MSG_ABC, 2'd0, 1'b1);
        check("tog abc known", hash, D_ABC);
        run_block("tog b1", MSG_NIST1, 2'd2, 1'b1);
        run_block("tog b2", MSG_NIST2, 2'd0, 1'b1);
        check("tog hdr known", hash, D_NIST);

        // Random messages with random types
        for (int n = 0; n < 8; n++) begin
            rm = rand_msg();
            rt = 2'($urandom_range(3));
            run_block($sformatf("rand%0d", n), rm, rt, n[0]);
        end

        // Final pulse must drop after one cycle
        @(negedge CLK);
        check("final pulse low", {255'h0, blk_done}, 256'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
